bht_counter_table: RTL
======================

# bht_counter_table

Branch history table that sits directly downstream of the branch unit. It consumes resolved conditional-branch outcomes and trains an array of 2-bit saturating counters indexed by PC. It returns a taken/not-taken prediction to the frontend for the PC currently being fetched. Clearing after reset and after `flush_bp_i` is done by a sequential walk, one entry per cycle, so the array maps to plain flops or a single-port-write RAM.

## Interface
- `NR_ENTRIES`, 64: number of counters; power of two, ≥ 2.
- `INSTR_ALIGN_BITS`, 1: low PC bits dropped before indexing (2-byte compressed alignment).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high; the only clock is `clk_i`.
- `flush_bp_i`  in  1  request a clear of the whole table.
- `debug_mode_i`  in  1  while high, updates are discarded.
- `vpc_i`  in  riscv::VLEN  fetch PC to predict.
- `bht_update_i`  in  ariane_pkg::bht_update_t  training input: `{valid, pc[VLEN], taken}`; `valid` is driven only for resolved conditional branches (cf_type == Branch).
- `pred_valid_o`  out  1  prediction usable.
- `pred_taken_o`  out  1  predicted direction.
- `init_busy_o`  out  1  clear walk in progress.

## Operation
- Index: `idx(pc) = pc[INSTR_ALIGN_BITS +: $clog2(NR_ENTRIES)]`. Upper PC bits are ignored, so aliasing is accepted.
- Counter encoding:
  - 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Prediction is `ctr[1]`.
  - Clear value is 01.
- Training:
  - taken: counter +1, saturating at 11.
  - not taken: counter −1, saturating at 00.
- FSM has two states, INIT and READY.
- INIT:
  - Writes 01 to the entry at `init_idx`, then increments `init_idx`.
  - Moves to READY after the write of entry `NR_ENTRIES-1`.
  - `init_busy_o=1`, `pred_valid_o=0`, `pred_taken_o=0`.
  - All updates are dropped.
- READY:
  - `pred_valid_o=1`, `pred_taken_o=ctr[idx(vpc_i)][1]`.
  - An update is applied when `bht_update_i.valid && !debug_mode_i`.
  - `flush_bp_i=1` moves to INIT with `init_idx=0`; an update in that same cycle is dropped.
- `flush_bp_i` during INIT restarts the walk at `init_idx=0`.
- `rst_i` has priority over everything else: state ← INIT, `init_idx` ← 0, and no array write occurs in that cycle.
- Counter contents are not reset directly; only the walk clears them.

## Timing
- Prediction path `vpc_i` → `pred_*_o` is combinational, with zero latency.
- Update latency is one cycle. An update presented in cycle t is visible to a lookup in t+1.
- No bypass: a lookup in cycle t of the same index sees the pre-update value.
- Clear walk takes exactly `NR_ENTRIES` cycles after the last cycle with `rst_i` or `flush_bp_i` high. For N=64, release of `rst_i` at edge e0 gives `init_busy_o=0` from cycle 64 onward.
- Output values while `rst_i` is high and in the cycles after it: `init_busy_o=1`, `pred_valid_o=0`, `pred_taken_o=0`.
- One update per cycle. Two updates to the same index in consecutive cycles both apply, e.g. 01 → 10 → 11.
- Counter arithmetic is 2-bit and never wraps: 11 + taken stays 11, 00 + not-taken stays 00.

## Structure
- In `ariane_pkg`:
  - `bht_update_t` struct `{logic valid; logic [riscv::VLEN-1:0] pc; logic taken;}`.
  - Counter constants `BHT_SNT=2'b00`, `BHT_WNT=2'b01`, `BHT_WT=2'b10`, `BHT_ST=2'b11`.
- The FSM state enum is local to the block.
- One sub-module, `bht_sat_ctr2`: a combinational saturating next-value function (`ctr`, `taken` → `ctr_n`), reusable by the BTB hysteresis.
- Array is `logic [1:0] ctr_q [NR_ENTRIES]`, with a single write port muxed between the walk and training.

## Test plan
- Reset and clear: hold `rst_i` 3 cycles, then release.
  - Cycles 0–63: `init_busy_o=1`, `pred_valid_o=0`.
  - Cycle 64: `pred_valid_o=1`; `pred_taken_o=0` for every `vpc_i`.
- Training sequence on pc 0x80000010 (idx 8): updates taken, taken, taken, not-taken.
  - Predictions in the following cycles: 1, 1, 1, 1 (counter 10, 11, 11, 10).
  - One further not-taken update gives 0.
- Saturation and no-bypass:
  - 5 not-taken updates on idx 3 keep the counter at 00.
  - A same-cycle lookup during the first taken update returns 0; the next cycle also returns 0 (counter 01).
- Aliasing and alignment: pc 0x1000 and 0x1080 share idx 0 (N=64). Training one with taken flips the prediction for the other. pc 0x1002 maps to idx 1.
- Flush mid-walk and in READY:
  - `flush_bp_i` at walk cycle 20 extends `init_busy_o` to 20+64 cycles.
  - Flush in READY coincident with an update: the update is dropped and all entries return to 01.
- Debug mode: with `debug_mode_i=1`, 4 taken updates on idx 5 leave the prediction at 0. The same updates with `debug_mode_i=0` raise it to 1 after the first.

Source files
------------

// File: rtl/ariane_pkg.sv
// Frontend types and branch-predictor counter encodings.
package ariane_pkg;

  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic                   taken;
  } bht_update_t;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

endpackage

// File: rtl/riscv.sv
// Core-wide architectural constants shared by the frontend blocks.
package riscv;

  localparam int unsigned VLEN = 64;

endpackage

// File: rtl/bht_sat_ctr2.sv
// Two-bit saturating counter next-value function; shared with the BTB hysteresis logic.
module bht_sat_ctr2
  import ariane_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_n_o
);

  always_comb begin
    ctr_n_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != BHT_ST) ctr_n_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != BHT_SNT) ctr_n_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/bht_counter_table.sv
// PC-indexed table of 2-bit direction counters, cleared by a one-entry-per-cycle walk.
module bht_counter_table
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES       = 64,
  parameter int unsigned INSTR_ALIGN_BITS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_bp_i,
  input  logic                   debug_mode_i,
  input  logic [riscv::VLEN-1:0] vpc_i,
  input  bht_update_t            bht_update_i,
  output logic                   pred_valid_o,
  output logic                   pred_taken_o,
  output logic                   init_busy_o
);

  localparam int unsigned IdxW = $clog2(NR_ENTRIES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NR_ENTRIES - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] init_idx_q, init_idx_d;
  logic [1:0]      ctr_q [NR_ENTRIES];

  logic [IdxW-1:0] pred_idx;
  logic [IdxW-1:0] upd_idx;
  logic [1:0]      upd_ctr_n;

  logic            ctr_we;
  logic [IdxW-1:0] ctr_waddr;
  logic [1:0]      ctr_wdata;

  assign pred_idx = vpc_i[INSTR_ALIGN_BITS +: IdxW];
  assign upd_idx  = bht_update_i.pc[INSTR_ALIGN_BITS +: IdxW];

  // Only the index slice of each PC matters; aliasing is accepted.
  logic unused_pc;
  assign unused_pc = ^{vpc_i, bht_update_i.pc};

  bht_sat_ctr2 u_sat_ctr (
    .ctr_i   (ctr_q[upd_idx]),
    .taken_i (bht_update_i.taken),
    .ctr_n_o (upd_ctr_n)
  );

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ctr_we     = 1'b0;
    ctr_waddr  = upd_idx;
    ctr_wdata  = upd_ctr_n;

    unique case (state_q)
      StInit: begin
        ctr_we     = 1'b1;
        ctr_waddr  = init_idx_q;
        ctr_wdata  = BHT_WNT;
        init_idx_d = init_idx_q + IdxW'(1);
        if (init_idx_q == LastIdx) state_d = StReady;
        if (flush_bp_i) begin
          init_idx_d = '0;
          state_d    = StInit;
        end
      end
      StReady: begin
        if (flush_bp_i) begin
          state_d    = StInit;
          init_idx_d = '0;
        end else if (bht_update_i.valid && !debug_mode_i) begin
          ctr_we = 1'b1;
        end
      end
      default: begin
        state_d    = StInit;
        init_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StInit;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Counter storage has no reset of its own; the walk is the only clear path.
  always_ff @(posedge clk_i) begin
    if (ctr_we && !rst_i) ctr_q[ctr_waddr] <= ctr_wdata;
  end

  // Outputs are forced to the clearing values while reset is asserted.
  assign init_busy_o  = (state_q == StInit) || rst_i;
  assign pred_valid_o = (state_q == StReady) && !rst_i;
  assign pred_taken_o = pred_valid_o && ctr_q[pred_idx][1];

endmodule
